voting_seq: RTL
===============

Name: voting_seq

Overview:
- Sequential ballot collector and tallier for 2**N candidates and up to 2**M voters.
- Ballots arrive one per cycle over a valid/ready stream, not as one packed word. Per-candidate counts are accumulated in registers.
- When the round closes, a 2**N-cycle sequential scan finds the winner. This is the streaming front end for voter-by-voter ballot feeds in the voting family, and it produces the same winner/count result.

Parameters:
N, 2, candidate index width; 2**N candidates
M, 2, voter-count exponent; at most 2**M ballots per round

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
vote_valid  input  1  ballot present on vote
vote  input  N  candidate index of the current ballot
vote_ready  output  1  block accepts a ballot this cycle
close  input  1  end the round early (level, sampled in COLLECT only)
winner  output  N  winning candidate of the last completed round
winner_count  output  M+1  vote count of winner
done  output  1  one-cycle pulse: winner/winner_count just updated

Behaviour:
- States: COLLECT, SCAN, DONE. Reset and power-up state is COLLECT.
- Reset (rst=1 at clock edge) has priority over everything else:
  - All 2**N counters, the ballot counter, the scan index and best registers go to 0.
  - winner=0, winner_count=0, done=0, state=COLLECT.
  - This holds in any state, including mid-round or mid-scan. Partial tallies are discarded.
- vote_ready = 1 iff state==COLLECT. It is a combinational decode of the state register and is 1 in the first cycle after reset.
- Accept = vote_valid & vote_ready. On accept:
  - count[vote] += 1.
  - ballots += 1.
  - Counters are M+1 bits wide. The maximum possible value is 2**M, so there is no overflow and no saturation logic.
- COLLECT -> SCAN when, at a clock edge:
  - an accept brings ballots to 2**M, or
  - close=1.
- Simultaneous close and accept: the ballot is counted, then the round closes.
- close with zero ballots is legal and produces winner=0, winner_count=0.
- SCAN:
  - vote_ready=0; ballots presented are neither accepted nor lost, since the sender holds vote_valid.
  - Scan index k runs from 0 to 2**N-1, one candidate per cycle. best_idx/best_cnt are initialised to 0/0 on entry.
  - If count[k] > best_cnt (strict), update best_idx=k and best_cnt=count[k]. Ties therefore resolve to the lowest candidate index.
  - close is ignored in SCAN.
- SCAN -> DONE after index 2**N-1 is processed.
- DONE lasts exactly one cycle:
  - done=1; winner=best_idx and winner_count=best_cnt are registered and visible in this same cycle.
  - All counts and ballots are cleared.
  - Next state is COLLECT.
- winner and winner_count hold their value until the next DONE or reset. done is 0 in every other cycle.
- Latency: last ballot accepted (or close sampled) at edge t; SCAN occupies cycles t+1..t+2**N; done=1 in cycle t+2**N+1. For defaults, done is high 5 cycles after the closing edge.
- Back-to-back rounds: a ballot presented during DONE is accepted in the following COLLECT cycle. Throughput is 2**M + 2**N + 1 cycles per full round.
- vote is don't-care when vote_valid=0. Every N-bit value is a legal candidate, so there is no range check.

Test Plan:
- N=2,M=2: after reset, stream ballots 2,2,1,3 on consecutive cycles:
  - vote_ready drops after the 4th accept;
  - done pulses exactly 5 cycles after the 4th accept edge with winner=2, winner_count=2;
  - vote_ready=1 the next cycle.
- Tie: ballots 1,3,3,1 -> winner=1, winner_count=2 (lowest index wins); all four 0 -> winner=0, winner_count=3'b100 (no overflow).
- Early close:
  - ballot 3 accepted with close=1 in the same cycle -> winner=3, winner_count=1;
  - next round close with no ballots -> winner=0, winner_count=0, done pulses once each round.
- Backpressure: hold vote_valid=1, vote=2 through SCAN/DONE:
  - vote_ready=0 and no count change during SCAN/DONE;
  - the held ballot is accepted in the first COLLECT cycle and counts only toward the new round.
- Reset mid-round:
  - accept 0,0, assert rst for one cycle -> winner/winner_count/done=0, vote_ready=1;
  - then ballot 1 + close -> winner=1, winner_count=1 (pre-reset ballots absent).
- Reset mid-SCAN:
  - assert rst at 2nd scan cycle -> no done pulse, outputs 0, state COLLECT next cycle;
  - winner retains 0 until the next completed round.

Source files
------------

// File: rtl/voting_seq.sv
// Streaming ballot collector: counts valid/ready ballots per candidate, then scans
// the tallies one candidate per cycle to register the winner and its vote count.
module voting_seq #(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vote_valid,
    input  logic [N-1:0] vote,
    output logic         vote_ready,
    input  logic         close,
    output logic [N-1:0] winner,
    output logic [M:0]   winner_count,
    output logic         done
);

    localparam int NC = 2 ** N;
    localparam logic [M:0]   LAST_BALLOT = (M+1)'((1 << M) - 1);
    localparam logic [N-1:0] LAST_IDX    = N'(NC - 1);

    typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;

    state_t         state, state_nxt;
    logic [M:0]     cnt [NC];
    logic [M:0]     ballots;
    logic [N-1:0]   scan_idx;
    logic [N-1:0]   best_idx;
    logic [M:0]     best_cnt;

    logic           accept;
    logic           round_full;
    logic           scan_last;
    logic [M:0]     cur_cnt;
    logic           take;
    logic [N-1:0]   best_idx_nxt;
    logic [M:0]     best_cnt_nxt;

    assign accept     = vote_valid & vote_ready;
    assign round_full = accept && (ballots == LAST_BALLOT);
    assign scan_last  = (scan_idx == LAST_IDX);

    // Strict compare keeps the earliest (lowest-index) candidate on ties.
    assign cur_cnt      = cnt[scan_idx];
    assign take         = (cur_cnt > best_cnt);
    assign best_idx_nxt = take ? scan_idx : best_idx;
    assign best_cnt_nxt = take ? cur_cnt  : best_cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        vote_ready = (state == COLLECT);
        case (state)
            COLLECT: if (round_full || close) state_nxt = SCAN;
            SCAN:    if (scan_last)           state_nxt = DONE;
            DONE:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) cnt[i] <= '0;
            ballots      <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            winner       <= '0;
            winner_count <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                COLLECT: begin
                    // Scan bookkeeping is parked at its start values while collecting.
                    scan_idx <= '0;
                    best_idx <= '0;
                    best_cnt <= '0;
                    if (accept) begin
                        cnt[vote] <= cnt[vote] + 1'b1;
                        ballots   <= ballots + 1'b1;
                    end
                end
                SCAN: begin
                    best_idx <= best_idx_nxt;
                    best_cnt <= best_cnt_nxt;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_last) begin
                        winner       <= best_idx_nxt;
                        winner_count <= best_cnt_nxt;
                        done         <= 1'b1;
                    end
                end
                DONE: begin
                    for (int i = 0; i < NC; i++) cnt[i] <= '0;
                    ballots <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
